blit_inner_seq: RTL
===================

// Module: blit_inner_seq
// PURPOSE
//  Inner-loop sequencer for the blitter write path. Counts pixels/phrases across one
//  inner span, runs source-read / dest-write memory cycles, and drives step_inner and
//  icount into the comparator control. It samples that block's nowrite to skip
//  inhibited writes. One instance per blitter, sits between outer-loop control and the
//  memory interface.
// PARAMETERS
//  CNT_W   16   width of inner count (pixels per span)
// PORTS
//  clk          in   1      system clock
//  resetl       in   1      synchronous reset, active low
//  start        in   1      one-cycle pulse: begin a span (ignored while busy)
//  inner_cnt    in   CNT_W  pixels in span, sampled on accepted start
//  srcen        in   1      source read required each step, sampled on start
//  phrase_mode  in   1      1 = step per 64-bit phrase, 0 = step per pixel; sampled on start
//  pixsize      in   3      pixel size code 0..5 = 1,2,4,8,16,32 bpp; sampled on start
//  nowrite      in   1      write inhibit from comparator control, valid in S_DWR
//  mem_ack      in   1      memory cycle complete (one-cycle pulse)
//  mem_req      out  1      memory cycle request, held until mem_ack
//  sread        out  1      current request is a source read
//  dwrite       out  1      current request is a destination write
//  step_inner   out  1      one-cycle pulse: advance inner loop (loads comparator bcompsel)
//  icount       out  3      bit index for bit-to-pixel expansion
//  wr_skip      out  1      one-cycle pulse: write suppressed by nowrite
//  busy         out  1      span in progress
//  done         out  1      one-cycle pulse: span finished
// BEHAVIOUR
//  - Reset (resetl=0 at clk edge): state S_IDLE, all outputs 0, remaining count 0,
//    icount 0. Reset mid-span abandons the span, even with mem_req high. No done pulse.
//  - States: S_IDLE, S_SRD, S_DWR, S_STEP, S_DONE. busy=1 in every state except S_IDLE.
//  - S_IDLE: start=1 loads remaining<=inner_cnt and icount<=0, and latches srcen,
//    phrase_mode and pixsize. If inner_cnt==0, go to S_DONE. Otherwise go to S_SRD
//    when srcen=1, else to S_DWR.
//  - S_SRD: mem_req=1, sread=1. Stay until mem_ack, then go to S_DWR.
//  - S_DWR, first cycle: nowrite=1 -> wr_skip=1, no request, next state S_STEP.
//    nowrite=0 -> mem_req=1, dwrite=1; hold until mem_ack, then S_STEP.
//    nowrite is sampled only in the first S_DWR cycle and ignored after.
//  - S_STEP (exactly 1 cycle): step_inner=1.
//    Decrement remaining by inc: inc=1 in pixel mode, inc=64>>pixsize in phrase mode.
//    Saturate at 0 when remaining<=inc (partial final phrase).
//    icount advances by 1 mod 8 in pixel mode and is held at 0 in phrase mode.
//    Next state S_DONE if the new remaining is 0, else S_SRD (srcen) or S_DWR.
//  - S_DONE (1 cycle): done=1, then go to S_IDLE. start arriving in S_DONE is ignored.
//  - mem_ack outside S_SRD/S_DWR is ignored. mem_req never drops before mem_ack.
//  - Minimum step period: 3 cycles with srcen=0 and immediate ack; 2 cycles when
//    nowrite skips the write.
//  - pixsize codes 6,7 are treated as 5 (32 bpp).
// TESTING
//  - Reset: hold resetl=0 for 2 clk -> mem_req, busy, done, step_inner=0, icount=0.
//  - Pixel span: start, inner_cnt=3, srcen=1, phrase_mode=0, ack after 1 cycle ->
//    3 sread/dwrite pairs, 3 step_inner pulses with icount 1,2,3 after each; done once.
//  - Phrase span: inner_cnt=10, pixsize=3 (8 pixels/phrase), phrase_mode=1, srcen=0 ->
//    2 dwrite cycles, 2 step_inner pulses, icount stays 0, then done.
//  - Inhibit: nowrite=1 in the 2nd S_DWR of a 3-pixel span -> that write gets no
//    mem_req and wr_skip=1; 3 step_inner pulses total; 2 dwrite cycles.
//  - Edges: inner_cnt=0 -> done 2 cycles after start with no mem_req.
//    start while busy is ignored. mem_ack delayed 5 cycles -> mem_req stays 1 throughout.
//  - Reset mid-span: resetl=0 while mem_req=1 in S_SRD -> next cycle idle, no done pulse.
//    A fresh start then completes normally.

Source files
------------

// File: rtl/blit_inner_seq.sv
// Inner-loop sequencer for the blitter write path: walks one inner span, issuing
// source-read / dest-write memory cycles and pulsing step_inner once per pixel or phrase.
module blit_inner_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetl,
    input  logic             start,
    input  logic [CNT_W-1:0] inner_cnt,
    input  logic             srcen,
    input  logic             phrase_mode,
    input  logic [2:0]       pixsize,
    input  logic             nowrite,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             sread,
    output logic             dwrite,
    output logic             step_inner,
    output logic [2:0]       icount,
    output logic             wr_skip,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SRD  = 3'd1,
        S_DWR  = 3'd2,
        S_STEP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic             srcen_q;
    logic             phrase_q;
    logic [2:0]       pixsize_q;

    logic [6:0]       inc;
    logic [CNT_W-1:0] inc_w;
    logic [CNT_W-1:0] rem_next;

    // A phrase is 64 bits, so it covers 64>>pixsize pixels; the last phrase may be partial.
    always_comb begin
        inc      = phrase_q ? (7'd64 >> pixsize_q) : 7'd1;
        inc_w    = CNT_W'(inc);
        rem_next = (remaining <= inc_w) ? '0 : remaining - inc_w;
    end

    // In S_DWR, mem_req low marks the first cycle, where nowrite decides skip vs. request.
    always_ff @(posedge clk) begin
        if (!resetl) begin
            state      <= S_IDLE;
            remaining  <= '0;
            srcen_q    <= 1'b0;
            phrase_q   <= 1'b0;
            pixsize_q  <= 3'd0;
            mem_req    <= 1'b0;
            sread      <= 1'b0;
            dwrite     <= 1'b0;
            step_inner <= 1'b0;
            icount     <= 3'd0;
            wr_skip    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            step_inner <= 1'b0;
            wr_skip    <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        remaining <= inner_cnt;
                        icount    <= 3'd0;
                        srcen_q   <= srcen;
                        phrase_q  <= phrase_mode;
                        pixsize_q <= (pixsize > 3'd5) ? 3'd5 : pixsize;
                        busy      <= 1'b1;
                        if (inner_cnt == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (srcen) begin
                            state   <= S_SRD;
                            mem_req <= 1'b1;
                            sread   <= 1'b1;
                        end else begin
                            state <= S_DWR;
                        end
                    end
                end
                S_SRD: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        sread   <= 1'b0;
                        state   <= S_DWR;
                    end
                end
                S_DWR: begin
                    if (!mem_req) begin
                        if (nowrite) begin
                            wr_skip    <= 1'b1;
                            step_inner <= 1'b1;
                            state      <= S_STEP;
                        end else begin
                            mem_req <= 1'b1;
                            dwrite  <= 1'b1;
                        end
                    end else if (mem_ack) begin
                        mem_req    <= 1'b0;
                        dwrite     <= 1'b0;
                        step_inner <= 1'b1;
                        state      <= S_STEP;
                    end
                end
                S_STEP: begin
                    remaining <= rem_next;
                    icount    <= phrase_q ? 3'd0 : icount + 3'd1;
                    if (rem_next == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (srcen_q) begin
                        state   <= S_SRD;
                        mem_req <= 1'b1;
                        sread   <= 1'b1;
                    end else begin
                        state <= S_DWR;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                    sread   <= 1'b0;
                    dwrite  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
